// File: rtl/sy_npu_pkg.sv
// Shared types for the NPU AXI round-robin scheduler: simplified AXI4
// channel payloads, the write FSM state enum and the response tracking entry.
package sy_npu_pkg;

  localparam int unsigned ID_W       = 4;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned PORT_IDX_W = 4;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA} w_state_e;

  typedef struct packed {
    logic [PORT_IDX_W-1:0] port;
    logic [ID_W-1:0]       id;
  } trk_entry_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
  } aw_chan_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
  } ar_chan_t;

  typedef struct packed {
    logic [DATA_W-1:0]   data;
    logic [DATA_W/8-1:0] strb;
    logic                last;
  } w_chan_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } b_chan_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } r_chan_t;

endpackage

// File: rtl/sy_npu_trk_fifo.sv
// In-order response tracking FIFO: remembers which port (and its original ID)
// each outstanding downstream request belongs to. Push while full is accepted
// only when a pop happens in the same cycle.
module sy_npu_trk_fifo
  import sy_npu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  trk_entry_t data_i,
  input  logic       pop_i,
  output trk_entry_t data_o,
  output logic       empty_o,
  output logic       full_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] CNT_ONE = (PTR_W+1)'(1);

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  trk_entry_t       mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage, no reset needed since occupancy guards every read
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/sy_npu_axi_rr_sched.sv
// Shares one AXI4 master port between PORT_NUM requesters. Reads are granted
// round-robin per cycle; writes are arbitrated by a small FSM that locks the
// winner for its whole burst. Responses are steered back through in-order
// tracking FIFOs. Optional per-port grant counters: SY_NPU_ARB_PERF_EN.
module sy_npu_axi_rr_sched
  import sy_npu_pkg::*;
#(
  parameter int unsigned PORT_NUM  = 2,
  parameter int unsigned MAX_OUTST = 4,
  parameter int unsigned DS_ID     = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic     [PORT_NUM-1:0]  inp_axi_aw_valid_i,
  output logic     [PORT_NUM-1:0]  inp_axi_aw_ready_o,
  input  aw_chan_t [PORT_NUM-1:0]  inp_axi_aw_bits_i,
  input  logic     [PORT_NUM-1:0]  inp_axi_ar_valid_i,
  output logic     [PORT_NUM-1:0]  inp_axi_ar_ready_o,
  input  ar_chan_t [PORT_NUM-1:0]  inp_axi_ar_bits_i,
  input  logic     [PORT_NUM-1:0]  inp_axi_w_valid_i,
  output logic     [PORT_NUM-1:0]  inp_axi_w_ready_o,
  input  w_chan_t  [PORT_NUM-1:0]  inp_axi_w_bits_i,
  output logic     [PORT_NUM-1:0]  inp_axi_r_valid_o,
  input  logic     [PORT_NUM-1:0]  inp_axi_r_ready_i,
  output r_chan_t  [PORT_NUM-1:0]  inp_axi_r_bits_o,
  output logic     [PORT_NUM-1:0]  inp_axi_b_valid_o,
  input  logic     [PORT_NUM-1:0]  inp_axi_b_ready_i,
  output b_chan_t  [PORT_NUM-1:0]  inp_axi_b_bits_o,
  output logic                     oup_axi_aw_valid_o,
  input  logic                     oup_axi_aw_ready_i,
  output aw_chan_t                 oup_axi_aw_bits_o,
  output logic                     oup_axi_ar_valid_o,
  input  logic                     oup_axi_ar_ready_i,
  output ar_chan_t                 oup_axi_ar_bits_o,
  output logic                     oup_axi_w_valid_o,
  input  logic                     oup_axi_w_ready_i,
  output w_chan_t                  oup_axi_w_bits_o,
  input  logic                     oup_axi_r_valid_i,
  output logic                     oup_axi_r_ready_o,
  input  r_chan_t                  oup_axi_r_bits_i,
  input  logic                     oup_axi_b_valid_i,
  output logic                     oup_axi_b_ready_o,
  input  b_chan_t                  oup_axi_b_bits_i
`ifdef SY_NPU_ARB_PERF_EN
  ,
  output logic [PORT_NUM-1:0][31:0] perf_grant_cnt_o
`endif
);

  localparam int unsigned     PORT_W  = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
  localparam logic [ID_W-1:0] DS_ID_V = ID_W'(DS_ID);

  function automatic logic [PORT_W-1:0] rr_next(input logic [PORT_W-1:0] idx);
    return (32'(idx) == PORT_NUM - 1) ? '0 : idx + PORT_W'(1);
  endfunction

  // MSB = something found, low bits = first requester at or after ptr
  function automatic logic [PORT_W:0] rr_pick(input logic [PORT_NUM-1:0] req,
                                              input logic [PORT_W-1:0]   ptr);
    logic [PORT_W:0]   res;
    logic [PORT_W-1:0] idx;
    res = '0;
    for (int unsigned i = 0; i < PORT_NUM; i++) begin
      idx = PORT_W'((32'(ptr) + i) % PORT_NUM);
      if (!res[PORT_W] && req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  logic [PORT_W-1:0] ar_ptr_q, ar_hold_idx_q, ar_idx, aw_ptr_q, w_port_q;
  logic [PORT_W:0]   ar_pick, aw_pick;
  logic              ar_hold_q, ar_sel, ar_go, ar_hs;
  logic              aw_go, aw_hs, w_go, w_hs, w_done;
  w_state_e          w_state_q;

  trk_entry_t        r_head, b_head, r_push_data, b_push_data;
  logic              r_empty, r_full, r_pop, r_space, r_act;
  logic              b_empty, b_full, b_pop, b_space, b_act;
  logic [PORT_W-1:0] r_port, b_port;
  logic              unused_bits;

  assign unused_bits = ^{oup_axi_r_bits_i.id, oup_axi_b_bits_i.id, r_head.port, b_head.port};

  // ---------------- read address arbitration ----------------
  // A stalled grant is held so a newly arriving higher-priority port cannot steal it
  assign ar_pick = rr_pick(inp_axi_ar_valid_i, ar_ptr_q);
  assign ar_idx  = ar_hold_q ? ar_hold_idx_q : ar_pick[PORT_W-1:0];
  assign ar_sel  = ar_hold_q || ar_pick[PORT_W];
  assign r_space = !r_full || r_pop;
  assign ar_go   = rst_ni && ar_sel && inp_axi_ar_valid_i[ar_idx] && r_space;
  assign ar_hs   = ar_go && oup_axi_ar_ready_i;

  assign r_push_data = '{port: PORT_IDX_W'(ar_idx), id: inp_axi_ar_bits_i[ar_idx].id};

  // AR grant hold and round-robin pointer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ar_ptr_q      <= '0;
      ar_hold_q     <= 1'b0;
      ar_hold_idx_q <= '0;
    end else begin
      ar_hold_q     <= ar_go && !oup_axi_ar_ready_i;
      ar_hold_idx_q <= ar_idx;
      if (ar_hs) ar_ptr_q <= rr_next(ar_idx);
    end
  end

  // Forward the AR winner downstream with the shared ID
  always_comb begin
    oup_axi_ar_valid_o = 1'b0;
    oup_axi_ar_bits_o  = '0;
    inp_axi_ar_ready_o = '0;
    if (ar_go) begin
      oup_axi_ar_valid_o         = 1'b1;
      oup_axi_ar_bits_o          = inp_axi_ar_bits_i[ar_idx];
      oup_axi_ar_bits_o.id       = DS_ID_V;
      inp_axi_ar_ready_o[ar_idx] = oup_axi_ar_ready_i;
    end
  end

  // ---------------- write path ----------------
  assign aw_pick = rr_pick(inp_axi_aw_valid_i, aw_ptr_q);
  assign b_space = !b_full || b_pop;
  assign aw_go   = (w_state_q == W_ADDR) && inp_axi_aw_valid_i[w_port_q];
  assign aw_hs   = aw_go && oup_axi_aw_ready_i;
  assign w_go    = (w_state_q == W_DATA) && inp_axi_w_valid_i[w_port_q];
  assign w_hs    = w_go && oup_axi_w_ready_i;
  assign w_done  = w_hs && inp_axi_w_bits_i[w_port_q].last;

  assign b_push_data = '{port: PORT_IDX_W'(w_port_q), id: inp_axi_aw_bits_i[w_port_q].id};

  // Write FSM: select a port, pass its AW, then its whole W burst
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state_q <= W_IDLE;
      w_port_q  <= '0;
      aw_ptr_q  <= '0;
    end else begin
      case (w_state_q)
        W_IDLE: if (aw_pick[PORT_W] && b_space) begin
          w_port_q  <= aw_pick[PORT_W-1:0];
          w_state_q <= W_ADDR;
        end
        W_ADDR: if (aw_hs) begin
          aw_ptr_q  <= rr_next(w_port_q);
          w_state_q <= W_DATA;
        end
        W_DATA: if (w_done) w_state_q <= W_IDLE;
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  // Forward the locked port's AW and W channels
  always_comb begin
    oup_axi_aw_valid_o = 1'b0;
    oup_axi_aw_bits_o  = '0;
    inp_axi_aw_ready_o = '0;
    oup_axi_w_valid_o  = 1'b0;
    oup_axi_w_bits_o   = '0;
    inp_axi_w_ready_o  = '0;
    if (aw_go) begin
      oup_axi_aw_valid_o           = 1'b1;
      oup_axi_aw_bits_o            = inp_axi_aw_bits_i[w_port_q];
      oup_axi_aw_bits_o.id         = DS_ID_V;
      inp_axi_aw_ready_o[w_port_q] = oup_axi_aw_ready_i;
    end
    if (w_go) begin
      oup_axi_w_valid_o           = 1'b1;
      oup_axi_w_bits_o            = inp_axi_w_bits_i[w_port_q];
      inp_axi_w_ready_o[w_port_q] = oup_axi_w_ready_i;
    end
  end

  // ---------------- response routing ----------------
  assign r_port            = PORT_W'(r_head.port);
  assign r_act             = rst_ni && !r_empty;
  assign oup_axi_r_ready_o = r_act && inp_axi_r_ready_i[r_port];
  assign r_pop             = r_act && oup_axi_r_valid_i && inp_axi_r_ready_i[r_port] && oup_axi_r_bits_i.last;

  assign b_port            = PORT_W'(b_head.port);
  assign b_act             = rst_ni && !b_empty;
  assign oup_axi_b_ready_o = b_act && inp_axi_b_ready_i[b_port];
  assign b_pop             = b_act && oup_axi_b_valid_i && inp_axi_b_ready_i[b_port];

  // Steer R beats to the port at the read FIFO head, restoring its ID
  always_comb begin
    inp_axi_r_valid_o = '0;
    inp_axi_r_bits_o  = '0;
    if (r_act) begin
      inp_axi_r_valid_o[r_port]   = oup_axi_r_valid_i;
      inp_axi_r_bits_o[r_port]    = oup_axi_r_bits_i;
      inp_axi_r_bits_o[r_port].id = r_head.id;
    end
  end

  // Steer B responses to the port at the write FIFO head, restoring its ID
  always_comb begin
    inp_axi_b_valid_o = '0;
    inp_axi_b_bits_o  = '0;
    if (b_act) begin
      inp_axi_b_valid_o[b_port]   = oup_axi_b_valid_i;
      inp_axi_b_bits_o[b_port]    = oup_axi_b_bits_i;
      inp_axi_b_bits_o[b_port].id = b_head.id;
    end
  end

  sy_npu_trk_fifo #(.DEPTH(MAX_OUTST)) u_r_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (ar_hs),
    .data_i  (r_push_data),
    .pop_i   (r_pop),
    .data_o  (r_head),
    .empty_o (r_empty),
    .full_o  (r_full)
  );

  sy_npu_trk_fifo #(.DEPTH(MAX_OUTST)) u_b_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (aw_hs),
    .data_i  (b_push_data),
    .pop_i   (b_pop),
    .data_o  (b_head),
    .empty_o (b_empty),
    .full_o  (b_full)
  );

`ifdef SY_NPU_ARB_PERF_EN
  logic [PORT_NUM-1:0][31:0] perf_cnt_q, perf_nxt;
  logic [1:0]                perf_inc;
  logic [32:0]               perf_sum;

  // Saturating per-port AW+AR grant counts
  always_comb begin
    perf_nxt = perf_cnt_q;
    perf_inc = '0;
    perf_sum = '0;
    for (int unsigned p = 0; p < PORT_NUM; p++) begin
      perf_inc    = {1'b0, aw_hs && (w_port_q == PORT_W'(p))} +
                    {1'b0, ar_hs && (ar_idx == PORT_W'(p))};
      perf_sum    = {1'b0, perf_cnt_q[p]} + 33'(perf_inc);
      perf_nxt[p] = perf_sum[32] ? '1 : perf_sum[31:0];
    end
  end

  // Counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) perf_cnt_q <= '0;
    else         perf_cnt_q <= perf_nxt;
  end

  assign perf_grant_cnt_o = perf_cnt_q;
`endif

endmodule

// File: tb/tb_sy_npu_axi_rr_sched.sv
// Directed bench for sy_npu_axi_rr_sched (2 ports, 4 outstanding, DS_ID 0).
// Inputs change on the falling edge, outputs are sampled 1ns later.
module tb_sy_npu_axi_rr_sched;
  import sy_npu_pkg::*;

  localparam int PN = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  logic [PN-1:0] aw_v, aw_r, ar_v, ar_r, w_v, w_r, r_v, r_r, b_v, b_r;
  aw_chan_t [PN-1:0] aw_bits;
  ar_chan_t [PN-1:0] ar_bits;
  w_chan_t  [PN-1:0] w_bits;
  r_chan_t  [PN-1:0] r_bits;
  b_chan_t  [PN-1:0] b_bits;
  logic oaw_v, oaw_r, oar_v, oar_r, ow_v, ow_r, or_v, or_r, ob_v, ob_r;
  aw_chan_t oaw_bits;
  ar_chan_t oar_bits;
  w_chan_t  ow_bits;
  r_chan_t  or_bits;
  b_chan_t  ob_bits;
`ifdef SY_NPU_ARB_PERF_EN
  logic [PN-1:0][31:0] perf;
`endif

  always #5 clk = ~clk;

  sy_npu_axi_rr_sched #(.PORT_NUM(PN), .MAX_OUTST(4), .DS_ID(0)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .inp_axi_aw_valid_i(aw_v), .inp_axi_aw_ready_o(aw_r), .inp_axi_aw_bits_i(aw_bits),
    .inp_axi_ar_valid_i(ar_v), .inp_axi_ar_ready_o(ar_r), .inp_axi_ar_bits_i(ar_bits),
    .inp_axi_w_valid_i(w_v),   .inp_axi_w_ready_o(w_r),   .inp_axi_w_bits_i(w_bits),
    .inp_axi_r_valid_o(r_v),   .inp_axi_r_ready_i(r_r),   .inp_axi_r_bits_o(r_bits),
    .inp_axi_b_valid_o(b_v),   .inp_axi_b_ready_i(b_r),   .inp_axi_b_bits_o(b_bits),
    .oup_axi_aw_valid_o(oaw_v), .oup_axi_aw_ready_i(oaw_r), .oup_axi_aw_bits_o(oaw_bits),
    .oup_axi_ar_valid_o(oar_v), .oup_axi_ar_ready_i(oar_r), .oup_axi_ar_bits_o(oar_bits),
    .oup_axi_w_valid_o(ow_v),   .oup_axi_w_ready_i(ow_r),   .oup_axi_w_bits_o(ow_bits),
    .oup_axi_r_valid_i(or_v),   .oup_axi_r_ready_o(or_r),   .oup_axi_r_bits_i(or_bits),
    .oup_axi_b_valid_i(ob_v),   .oup_axi_b_ready_o(ob_r),   .oup_axi_b_bits_i(ob_bits)
`ifdef SY_NPU_ARB_PERF_EN
    , .perf_grant_cnt_o(perf)
`endif
  );

  task automatic clear_inputs();
    aw_v = '0; ar_v = '0; w_v = '0; r_r = '0; b_r = '0;
    aw_bits = '0; ar_bits = '0; w_bits = '0;
    oaw_r = 1'b0; oar_r = 1'b0; ow_r = 1'b0; or_v = 1'b0; ob_v = 1'b0;
    or_bits = '0; ob_bits = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    ar_v = '1; aw_v = 2'b01; w_v = 2'b01; r_r = '1; b_r = '1;
    oar_r = 1'b1; oaw_r = 1'b1; ow_r = 1'b1; or_v = 1'b1; ob_v = 1'b1;
    #1;
    total++; if ({oar_v, oaw_v, ow_v} !== 3'b000) begin bad++; $display("FAIL rst_oup_valid got=%b exp=000", {oar_v, oaw_v, ow_v}); end
    total++; if ({ar_r, aw_r, w_r} !== 6'b0) begin bad++; $display("FAIL rst_inp_ready got=%b exp=0", {ar_r, aw_r, w_r}); end
    total++; if ({r_v, b_v, or_r, ob_r} !== 6'b0) begin bad++; $display("FAIL rst_resp got=%b exp=0", {r_v, b_v, or_r, ob_r}); end
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    or_v = 1'b1; ob_v = 1'b1; r_r = '1; b_r = '1;
    #1;
    total++; if ({or_r, ob_r, r_v, b_v} !== 6'b0) begin bad++; $display("FAIL empty_fifo_resp got=%b exp=0", {or_r, ob_r, r_v, b_v}); end
    clear_inputs();
  endtask

  task automatic test_ar_rr();
    @(negedge clk);
    ar_bits[0].id = 4'd3; ar_bits[0].addr = 32'h1000;
    ar_bits[1].id = 4'd5; ar_bits[1].addr = 32'h2000;
    ar_v = 2'b11; oar_r = 1'b1;
    #1;
    total++; if (oar_v !== 1'b1 || oar_bits.addr !== 32'h1000) begin bad++; $display("FAIL ar_first got=%b/%h exp=1/1000", oar_v, oar_bits.addr); end
    total++; if (oar_bits.id !== 4'd0) begin bad++; $display("FAIL ar_ds_id got=%0d exp=0", oar_bits.id); end
    total++; if (ar_r !== 2'b01) begin bad++; $display("FAIL ar_ready0 got=%b exp=01", ar_r); end
    @(negedge clk);
    ar_v = 2'b10;
    #1;
    total++; if (ar_r !== 2'b10 || oar_bits.addr !== 32'h2000) begin bad++; $display("FAIL ar_second got=%b/%h exp=10/2000", ar_r, oar_bits.addr); end
    @(negedge clk);
    ar_v = '0; oar_r = 1'b0;
    or_v = 1'b1; or_bits.id = 4'd0; or_bits.data = 32'hAA; or_bits.last = 1'b1; r_r = 2'b11;
    #1;
    total++; if (r_v !== 2'b01 || r_bits[0].id !== 4'd3 || r_bits[0].data !== 32'hAA) begin bad++; $display("FAIL r_route0 got=%b/%0d/%h exp=01/3/aa", r_v, r_bits[0].id, r_bits[0].data); end
    @(negedge clk);
    or_bits.data = 32'hBB;
    #1;
    total++; if (r_v !== 2'b10 || r_bits[1].id !== 4'd5 || r_bits[1].data !== 32'hBB) begin bad++; $display("FAIL r_route1 got=%b/%0d/%h exp=10/5/bb", r_v, r_bits[1].id, r_bits[1].data); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_outstanding();
    @(negedge clk);
    ar_v = 2'b01; oar_r = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      ar_bits[0].id = 4'(k);
      #1;
      total++; if (ar_r !== 2'b01) begin bad++; $display("FAIL ar_accept%0d got=%b exp=01", k, ar_r); end
      @(negedge clk);
    end
    ar_bits[0].id = 4'd5;
    #1;
    total++; if (ar_r !== 2'b00 || oar_v !== 1'b0) begin bad++; $display("FAIL ar_full got=%b/%b exp=00/0", ar_r, oar_v); end
    or_v = 1'b1; or_bits.last = 1'b0; or_bits.data = 32'h11; r_r = 2'b01;
    #1;
    total++; if (ar_r !== 2'b00 || r_bits[0].id !== 4'd1) begin bad++; $display("FAIL ar_full_nonlast got=%b/%0d exp=00/1", ar_r, r_bits[0].id); end
    @(negedge clk);
  endtask

  task automatic test_full_push_pop();
    or_bits.last = 1'b1;
    #1;
    total++; if (ar_r !== 2'b01 || oar_v !== 1'b1) begin bad++; $display("FAIL push_pop_accept got=%b/%b exp=01/1", ar_r, oar_v); end
    @(negedge clk);
    ar_v = '0; or_v = 1'b0;
    #1;
    total++; if (dut.u_r_fifo.count_q !== 3'd4) begin bad++; $display("FAIL push_pop_count got=%0d exp=4", dut.u_r_fifo.count_q); end
    for (int k = 2; k <= 5; k++) begin
      or_v = 1'b1;
      #1;
      total++; if (r_v !== 2'b01 || r_bits[0].id !== 4'(k)) begin bad++; $display("FAIL drain_id%0d got=%b/%0d exp=01/%0d", k, r_v, r_bits[0].id, k); end
      @(negedge clk);
    end
    or_v = 1'b0;
    clear_inputs();
  endtask

  task automatic test_write_lock();
    @(negedge clk);
    aw_bits[1].id = 4'd7; aw_bits[1].addr = 32'h3000; aw_bits[1].len = 8'd3;
    aw_v = 2'b10; oaw_r = 1'b1; ow_r = 1'b1;
    #1;
    total++; if (oaw_v !== 1'b0) begin bad++; $display("FAIL aw_idle got=%b exp=0", oaw_v); end
    @(negedge clk);
    aw_bits[0].id = 4'd2; aw_bits[0].addr = 32'h4000; aw_bits[0].len = 8'd0;
    aw_v = 2'b11;
    #1;
    total++; if (oaw_v !== 1'b1 || oaw_bits.addr !== 32'h3000 || oaw_bits.len !== 8'd3 || oaw_bits.id !== 4'd0) begin bad++; $display("FAIL aw_port1 got=%b/%h/%0d/%0d exp=1/3000/3/0", oaw_v, oaw_bits.addr, oaw_bits.len, oaw_bits.id); end
    total++; if (aw_r !== 2'b10) begin bad++; $display("FAIL aw_ready1 got=%b exp=10", aw_r); end
    @(negedge clk);
    aw_v = 2'b01; w_v = 2'b11;
    w_bits[0].data = 32'hDEAD; w_bits[0].last = 1'b1;
    for (int b = 0; b < 4; b++) begin
      w_bits[1].data = 32'h10 + 32'(b); w_bits[1].last = (b == 3);
      #1;
      total++; if (ow_v !== 1'b1 || ow_bits.data !== 32'h10 + 32'(b) || w_r !== 2'b10 || aw_r !== 2'b00) begin bad++; $display("FAIL w_beat%0d got=%b/%h/%b/%b exp=1/%h/10/00", b, ow_v, ow_bits.data, w_r, aw_r, 32'h10 + 32'(b)); end
      @(negedge clk);
    end
    w_v = 2'b01;
    #1;
    total++; if (aw_r !== 2'b00 || ow_v !== 1'b0) begin bad++; $display("FAIL w_after_last got=%b/%b exp=00/0", aw_r, ow_v); end
    @(negedge clk);
    #1;
    total++; if (aw_r !== 2'b01 || oaw_bits.addr !== 32'h4000) begin bad++; $display("FAIL aw_port0 got=%b/%h exp=01/4000", aw_r, oaw_bits.addr); end
    @(negedge clk);
    aw_v = '0;
    #1;
    total++; if (w_r !== 2'b01 || ow_bits.data !== 32'hDEAD) begin bad++; $display("FAIL w_port0 got=%b/%h exp=01/dead", w_r, ow_bits.data); end
    @(negedge clk);
    w_v = '0;
    ob_v = 1'b1; ob_bits.id = 4'd0; ob_bits.resp = 2'b00; b_r = 2'b11;
    #1;
    total++; if (b_v !== 2'b10 || b_bits[1].id !== 4'd7) begin bad++; $display("FAIL b_route1 got=%b/%0d exp=10/7", b_v, b_bits[1].id); end
    @(negedge clk);
    ob_bits.resp = 2'b10;
    #1;
    total++; if (b_v !== 2'b01 || b_bits[0].id !== 4'd2 || b_bits[0].resp !== 2'b10) begin bad++; $display("FAIL b_route0 got=%b/%0d/%b exp=01/2/10", b_v, b_bits[0].id, b_bits[0].resp); end
    @(negedge clk);
    ob_v = 1'b0;
    #1;
    total++; if (ob_r !== 1'b0) begin bad++; $display("FAIL b_empty got=%b exp=0", ob_r); end
    clear_inputs();
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk);
    aw_bits[0].id = 4'd9; aw_bits[0].len = 8'd3; aw_v = 2'b01; oaw_r = 1'b1; ow_r = 1'b1;
    @(negedge clk);
    @(negedge clk);
    aw_v = '0; w_v = 2'b01; w_bits[0].data = 32'h1; w_bits[0].last = 1'b0;
    #1;
    total++; if (ow_v !== 1'b1) begin bad++; $display("FAIL burst_beat1 got=%b exp=1", ow_v); end
    @(negedge clk);
    w_bits[0].data = 32'h2;
    ar_v = 2'b10; oar_r = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    total++; if ({ow_v, oaw_v, oar_v, w_r, ar_r} !== 7'b0) begin bad++; $display("FAIL rst_mid_outputs got=%b exp=0", {ow_v, oaw_v, oar_v, w_r, ar_r}); end
    total++; if (dut.w_state_q !== W_IDLE) begin bad++; $display("FAIL rst_mid_state got=%0d exp=%0d", dut.w_state_q, W_IDLE); end
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;
    aw_bits[1].id = 4'd4; aw_bits[1].addr = 32'h5000; aw_v = 2'b10; oaw_r = 1'b1; ow_r = 1'b1;
    @(negedge clk);
    #1;
    total++; if (aw_r !== 2'b10 || oaw_bits.addr !== 32'h5000) begin bad++; $display("FAIL post_rst_aw got=%b/%h exp=10/5000", aw_r, oaw_bits.addr); end
    @(negedge clk);
    aw_v = '0; w_v = 2'b10; w_bits[1].data = 32'h77; w_bits[1].last = 1'b1;
    #1;
    total++; if (w_r !== 2'b10 || ow_bits.data !== 32'h77) begin bad++; $display("FAIL post_rst_w got=%b/%h exp=10/77", w_r, ow_bits.data); end
    @(negedge clk);
    w_v = '0; ob_v = 1'b1; b_r = 2'b10;
    #1;
    total++; if (b_v !== 2'b10 || b_bits[1].id !== 4'd4) begin bad++; $display("FAIL post_rst_b got=%b/%0d exp=10/4", b_v, b_bits[1].id); end
    @(negedge clk);
    clear_inputs();
  endtask

`ifdef SY_NPU_ARB_PERF_EN
  task automatic test_perf();
    @(negedge clk);
    aw_v = 2'b01; oaw_r = 1'b1; oar_r = 1'b1; ow_r = 1'b1;
    @(negedge clk);
    ar_v = 2'b01;
    #1;
    total++; if (aw_r !== 2'b01 || ar_r !== 2'b01) begin bad++; $display("FAIL perf_dual_grant got=%b/%b exp=01/01", aw_r, ar_r); end
    @(negedge clk);
    aw_v = '0; ar_v = '0; w_v = 2'b01; w_bits[0].last = 1'b1;
    #1;
    total++; if (perf[0] !== 32'd2 || perf[1] !== 32'd1) begin bad++; $display("FAIL perf_count got=%0d/%0d exp=2/1", perf[0], perf[1]); end
    @(negedge clk);
    w_v = '0;
    force dut.perf_cnt_q[0] = 32'hFFFF_FFFE;
    #1;
    release dut.perf_cnt_q[0];
    aw_v = 2'b01;
    @(negedge clk);
    ar_v = 2'b01;
    @(negedge clk);
    aw_v = '0; ar_v = '0;
    #1;
    total++; if (perf[0] !== 32'hFFFF_FFFF) begin bad++; $display("FAIL perf_saturate got=%h exp=ffffffff", perf[0]); end
    clear_inputs();
  endtask
`endif

  initial begin
    clear_inputs();
    test_reset();
    test_ar_rr();
    test_outstanding();
    test_full_push_pop();
    test_write_lock();
    test_reset_mid_burst();
`ifdef SY_NPU_ARB_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
